fifo_stream_reader: RTL and testbench

- Read-side drain stage that sits directly downstream of the synchronous FIFO (`fifo`).
- Pulls words from the FIFO's `rd_en`/`dout`/`empty` interface, hides the FIFO's one-cycle read latency with a 2-entry output buffer, and presents a valid/ready stream.
- Sustains one word per cycle when the consumer is always ready.
- Frames the stream into fixed-length bursts with an `m_last` marker.

---
 rtl/fifo_stream_reader.sv | 150 +++++++++++++++
 tb/tb_fifo_stream_reader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// fifo_stream_reader
//
// Read-side drain stage placed directly after a synchronous FIFO. It issues
// FIFO reads, absorbs the FIFO's one-cycle read latency in a 2-entry circular
// buffer, and presents the words as a valid/ready stream. The stream is framed
// into fixed-length bursts, and m_last marks the final beat of each burst.
//
// Parameters:
//   width : data word width (must match the FIFO word width)
//   burst : beats per burst, 1..65535; m_last marks beat burst-1
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   enable     in   1 = new FIFO reads may be issued; 0 = only drain
//   fifo_empty in   FIFO empty flag
//   fifo_dout  in   FIFO read data, valid the cycle after a read edge
//   fifo_rd_en out  FIFO read enable (combinational)
//   m_data     out  stream data (registered)
//   m_valid    out  stream valid (registered)
//   m_ready    in   consumer ready
//   m_last     out  last beat of burst (registered)
//   buf_level  out  entries held in the output buffer (0..2)
// -----------------------------------------------------------------------------
module fifo_stream_reader #(
    parameter int width = 16,
    parameter int burst = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [width-1:0] fifo_dout,
    output logic             fifo_rd_en,
    output logic [width-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             m_last,
    output logic [1:0]       buf_level
);

    localparam logic [15:0] LastBeat = 16'(burst - 1);

    // Registered state
    logic             inflight_q;
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       level_q;
    logic [width-1:0] mem_q [2];
    logic [15:0]      beat_q;
    logic [width-1:0] data_q;
    logic             valid_q;
    logic             last_q;

    // Next-state values
    logic             inflight_d;
    logic             wr_ptr_d;
    logic             rd_ptr_d;
    logic [1:0]       level_d;
    logic [width-1:0] mem_d [2];
    logic [15:0]      beat_d;
    logic [width-1:0] data_d;
    logic             valid_d;
    logic             last_d;

    // Combinational helpers
    logic             pop_s;
    logic [2:0]       occ_s;
    logic             rd_en_s;

    // Read issue, buffer bookkeeping and next-state output values
    always_comb begin
        pop_s = valid_q & m_ready;

        // Occupancy after this edge: buffered + in-flight - popped. The same
        // sum is both the read-issue limit and the next buffer level, because
        // an in-flight word always lands in the buffer at the next edge.
        occ_s = {1'b0, level_q} + {2'b00, inflight_q} - {2'b00, pop_s};

        rd_en_s    = !rst & enable & !fifo_empty & (occ_s < 3'd2);
        inflight_d = rd_en_s;
        level_d    = occ_s[1:0];

        wr_ptr_d = wr_ptr_q ^ inflight_q;
        rd_ptr_d = rd_ptr_q ^ pop_s;

        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        if (inflight_q) begin
            mem_d[wr_ptr_q] = fifo_dout;
        end else begin
            mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
        end

        if (pop_s) begin
            if (last_q) begin
                beat_d = 16'd0;
            end else begin
                beat_d = beat_q + 16'd1;
            end
        end else begin
            beat_d = beat_q;
        end

        // Outputs are registered from the post-edge buffer view; data holds
        // its last value once the buffer runs dry.
        valid_d = (level_d != 2'd0);
        if (valid_d) begin
            data_d = mem_d[rd_ptr_d];
        end else begin
            data_d = data_q;
        end
        last_d = valid_d & (beat_d == LastBeat);
    end

    // State register with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight_q <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            level_q    <= 2'd0;
            mem_q[0]   <= {width{1'b0}};
            mem_q[1]   <= {width{1'b0}};
            beat_q     <= 16'd0;
            data_q     <= {width{1'b0}};
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            mem_q[0]   <= mem_d[0];
            mem_q[1]   <= mem_d[1];
            beat_q     <= beat_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
        end
    end

    assign fifo_rd_en = rd_en_s;
    assign m_data     = data_q;
    assign m_valid    = valid_q;
    assign m_last     = last_q;
    assign buf_level  = level_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// -----------------------------------------------------------------------------
// Testbench for fifo_stream_reader. A small behavioural FIFO feeds two DUT
// instances (burst=4 and burst=1) that see identical inputs; only the burst=4
// instance drives the FIFO read enable. Reads never depend on burst, so both
// instances stay in lockstep.
// -----------------------------------------------------------------------------
module tb_fifo_stream_reader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        m_ready = 1'b0;
    logic        push_v = 1'b0;
    logic [15:0] push_d = 16'd0;

    logic        fifo_empty;
    logic [15:0] fifo_dout = 16'd0;
    logic        fifo_rd_en;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic [1:0]  buf_level;

    logic        rd_en1;
    logic [15:0] m_data1;
    logic        m_valid1;
    logic        m_last1;
    logic [1:0]  buf_level1;

    int n_chk  = 0;
    int n_pass = 0;

    // Behavioural FIFO model
    logic [15:0] fm [0:63];
    int head = 0;
    int tail = 0;
    assign fifo_empty = (head == tail);

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            head <= 0;
            tail <= 0;
        end else begin
            if (push_v) begin
                fm[tail[5:0]] <= push_d;
                tail <= tail + 1;
            end
            if (fifo_rd_en && !fifo_empty) begin
                fifo_dout <= fm[head[5:0]];
                head <= head + 1;
            end
        end
    end

    fifo_stream_reader #(.width(16), .burst(4)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .buf_level(buf_level)
    );

    fifo_stream_reader #(.width(16), .burst(1)) u_dut1 (
        .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_dout(fifo_dout), .fifo_rd_en(rd_en1), .m_data(m_data1),
        .m_valid(m_valid1), .m_ready(m_ready), .m_last(m_last1),
        .buf_level(buf_level1)
    );

    // Reset pulse of one cycle, leaving inputs idle; ends on a falling edge
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; enable = 1'b0; m_ready = 1'b0; push_v = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Push n consecutive words starting at base; ends on a falling edge
    task automatic push_words(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            push_v = 1'b1;
            push_d = base + 16'(i);
            @(negedge clk);
        end
        push_v = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; m_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_chk++; if (m_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", m_valid); else n_pass++;
        n_chk++; if (fifo_rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b expected 0", fifo_rd_en); else n_pass++;
        n_chk++; if (buf_level !== 2'd0) $display("FAIL reset_level: got %0d expected 0", buf_level); else n_pass++;
        n_chk++; if (m_data !== 16'h0000) $display("FAIL reset_data: got %h expected 0000", m_data); else n_pass++;
        rst = 1'b0; enable = 1'b0; m_ready = 1'b1;
        push_words(16'h1234, 1);
        enable = 1'b1;
        #1;
        n_chk++; if (fifo_rd_en !== 1'b1) $display("FAIL single_rd_c0: got %b expected 1", fifo_rd_en); else n_pass++;
        @(negedge clk); #1;
        n_chk++; if (fifo_rd_en !== 1'b0) $display("FAIL single_rd_c1: got %b expected 0", fifo_rd_en); else n_pass++;
        n_chk++; if (m_valid !== 1'b0) $display("FAIL single_valid_c1: got %b expected 0", m_valid); else n_pass++;
        @(negedge clk); #1;
        n_chk++; if (m_valid !== 1'b1) $display("FAIL single_valid_c2: got %b expected 1", m_valid); else n_pass++;
        n_chk++; if (m_data !== 16'h1234) $display("FAIL single_data: got %h expected 1234", m_data); else n_pass++;
        n_chk++; if (m_last !== 1'b0) $display("FAIL single_last: got %b expected 0", m_last); else n_pass++;
    endtask

    task automatic test_full_rate();
        int got = 0;
        int c0 = -1;
        do_reset();
        push_words(16'd1, 8);
        enable = 1'b1; m_ready = 1'b1;
        for (int c = 0; c < 30 && got < 8; c++) begin
            #1;
            if (m_valid) begin
                if (c0 < 0) c0 = c;
                n_chk++; if (m_data !== 16'(got + 1)) $display("FAIL stream_data[%0d]: got %h expected %h", got, m_data, 16'(got + 1)); else n_pass++;
                n_chk++; if (m_last !== (got == 3 || got == 7)) $display("FAIL stream_last[%0d]: got %b expected %b", got, m_last, (got == 3 || got == 7)); else n_pass++;
                n_chk++; if (c !== c0 + got) $display("FAIL stream_gap[%0d]: got cycle %0d expected %0d", got, c, c0 + got); else n_pass++;
                got++;
            end
            @(negedge clk);
        end
        n_chk++; if (got !== 8) $display("FAIL stream_count: got %0d expected 8", got); else n_pass++;
    endtask

    task automatic test_backpressure();
        int rd_cnt = 0;
        int got = 0;
        do_reset();
        push_words(16'hA000, 6);
        enable = 1'b1; m_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (fifo_rd_en) rd_cnt++;
            @(negedge clk);
        end
        #1;
        n_chk++; if (rd_cnt !== 2) $display("FAIL bp_reads: got %0d expected 2", rd_cnt); else n_pass++;
        n_chk++; if (buf_level !== 2'd2) $display("FAIL bp_level: got %0d expected 2", buf_level); else n_pass++;
        for (int c = 0; c < 3; c++) begin
            n_chk++; if (fifo_rd_en !== 1'b0) $display("FAIL bp_rd_hold: got %b expected 0", fifo_rd_en); else n_pass++;
            n_chk++; if (m_data !== 16'hA000 || m_valid !== 1'b1) $display("FAIL bp_data_hold: got %h/%b expected a000/1", m_data, m_valid); else n_pass++;
            @(negedge clk); #1;
        end
        @(negedge clk);
        m_ready = 1'b1;
        for (int c = 0; c < 30 && got < 6; c++) begin
            #1;
            if (m_valid) begin
                n_chk++; if (m_data !== 16'hA000 + 16'(got)) $display("FAIL bp_data[%0d]: got %h expected %h", got, m_data, 16'hA000 + 16'(got)); else n_pass++;
                got++;
            end
            @(negedge clk);
        end
        n_chk++; if (got !== 6) $display("FAIL bp_count: got %0d expected 6", got); else n_pass++;
        #1;
        n_chk++; if (m_valid !== 1'b0) $display("FAIL bp_drained: got %b expected 0", m_valid); else n_pass++;
    endtask

    task automatic test_enable_gating();
        int issued = 0;
        int got = 0;
        logic [15:0] dat [0:9];
        logic        lst [0:9];
        do_reset();
        push_words(16'h0100, 10);
        enable = 1'b1; m_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (m_valid && got < 10) begin dat[got] = m_data; lst[got] = m_last; got++; end
            if (fifo_rd_en) issued++;
            if (issued == 3) break;
            @(negedge clk);
        end
        @(negedge clk);
        enable = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            n_chk++; if (fifo_rd_en !== 1'b0) $display("FAIL gate_rd_en: got %b expected 0", fifo_rd_en); else n_pass++;
            if (m_valid && got < 10) begin dat[got] = m_data; lst[got] = m_last; got++; end
            @(negedge clk);
        end
        n_chk++; if (got !== 3) $display("FAIL gate_drained: got %0d expected 3", got); else n_pass++;
        enable = 1'b1;
        for (int c = 0; c < 30 && got < 10; c++) begin
            #1;
            if (m_valid) begin dat[got] = m_data; lst[got] = m_last; got++; end
            @(negedge clk);
        end
        n_chk++; if (got !== 10) $display("FAIL gate_count: got %0d expected 10", got); else n_pass++;
        for (int i = 0; i < got; i++) begin
            n_chk++; if (dat[i] !== 16'h0100 + 16'(i)) $display("FAIL gate_data[%0d]: got %h expected %h", i, dat[i], 16'h0100 + 16'(i)); else n_pass++;
            n_chk++; if (lst[i] !== (i == 3 || i == 7)) $display("FAIL gate_last[%0d]: got %b expected %b", i, lst[i], (i == 3 || i == 7)); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_burst();
        int acc = 0;
        int got = 0;
        do_reset();
        push_words(16'h5100, 6);
        enable = 1'b1; m_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (m_valid && m_ready) acc++;
            if (acc == 2) break;
            @(negedge clk);
        end
        @(negedge clk);
        m_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_chk++; if (buf_level !== 2'd2) $display("FAIL mid_level: got %0d expected 2", buf_level); else n_pass++;
        n_chk++; if (m_data !== 16'h5102) $display("FAIL mid_data: got %h expected 5102", m_data); else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_chk++; if (m_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b expected 0", m_valid); else n_pass++;
        n_chk++; if (m_last !== 1'b0) $display("FAIL mid_rst_last: got %b expected 0", m_last); else n_pass++;
        n_chk++; if (buf_level !== 2'd0) $display("FAIL mid_rst_level: got %0d expected 0", buf_level); else n_pass++;
        n_chk++; if (fifo_rd_en !== 1'b0) $display("FAIL mid_rst_rd_en: got %b expected 0", fifo_rd_en); else n_pass++;
        @(negedge clk);
        rst = 1'b0; enable = 1'b0;
        push_words(16'h5200, 5);
        enable = 1'b1; m_ready = 1'b1;
        for (int c = 0; c < 30 && got < 5; c++) begin
            #1;
            if (m_valid) begin
                n_chk++; if (m_data !== 16'h5200 + 16'(got)) $display("FAIL post_rst_data[%0d]: got %h expected %h", got, m_data, 16'h5200 + 16'(got)); else n_pass++;
                n_chk++; if (m_last !== (got == 3)) $display("FAIL post_rst_last[%0d]: got %b expected %b", got, m_last, (got == 3)); else n_pass++;
                got++;
            end
            @(negedge clk);
        end
        n_chk++; if (got !== 5) $display("FAIL post_rst_count: got %0d expected 5", got); else n_pass++;
    endtask

    task automatic test_burst1();
        int got = 0;
        do_reset();
        push_words(16'h6000, 3);
        enable = 1'b1; m_ready = 1'b1;
        for (int c = 0; c < 20 && got < 3; c++) begin
            #1;
            if (m_valid1) begin
                n_chk++; if (m_data1 !== 16'h6000 + 16'(got)) $display("FAIL b1_data[%0d]: got %h expected %h", got, m_data1, 16'h6000 + 16'(got)); else n_pass++;
                n_chk++; if (m_last1 !== 1'b1) $display("FAIL b1_last[%0d]: got %b expected 1", got, m_last1); else n_pass++;
                got++;
            end
            @(negedge clk);
        end
        n_chk++; if (got !== 3) $display("FAIL b1_count: got %0d expected 3", got); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_full_rate();
        test_backpressure();
        test_enable_gating();
        test_reset_mid_burst();
        test_burst1();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
